// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: EX operand-mux selects, IF/ID stall, ID/EX bubble
// and a mul/div busy counter, all derived from an internal shadow copy of EX/MEM/WB.
module hazard_fwd_ctrl #(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_regwrite,
  input  logic             i_id_load,
  input  logic             i_id_md_start,
  input  logic             i_id_md_use,
  input  logic             i_flush,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic             o_stall,
  output logic             o_bubble,
  output logic             o_md_busy
);

  localparam logic [CNT_W-1:0] LP_MD_LOAD = CNT_W'(MD_CYCLES);

  logic             r_ex_valid;
  logic [4:0]       r_ex_rd;
  logic             r_ex_regwrite;
  logic             r_ex_load;
  logic [4:0]       r_ex_rs;
  logic [4:0]       r_ex_rt;
  logic             r_ex_use_rs;
  logic             r_ex_use_rt;

  // The load flag only matters while the producer sits in EX, so MEM/WB drop it.
  logic             r_mem_valid;
  logic [4:0]       r_mem_rd;
  logic             r_mem_regwrite;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic             r_wb_regwrite;

  logic [CNT_W-1:0] r_cnt;

  logic w_a_mem, w_a_wb, w_b_mem, w_b_wb;
  logic w_lu, w_mdh, w_stall, w_accept;

  assign w_a_mem = r_ex_valid & r_ex_use_rs & (r_ex_rs != 5'd0) &
                   r_mem_valid & r_mem_regwrite & (r_mem_rd == r_ex_rs);
  assign w_a_wb  = r_ex_valid & r_ex_use_rs & (r_ex_rs != 5'd0) &
                   r_wb_valid & r_wb_regwrite & (r_wb_rd == r_ex_rs);
  assign w_b_mem = r_ex_valid & r_ex_use_rt & (r_ex_rt != 5'd0) &
                   r_mem_valid & r_mem_regwrite & (r_mem_rd == r_ex_rt);
  assign w_b_wb  = r_ex_valid & r_ex_use_rt & (r_ex_rt != 5'd0) &
                   r_wb_valid & r_wb_regwrite & (r_wb_rd == r_ex_rt);

  // MEM holds the younger result, so it wins over WB for the same register.
  always_comb begin
    o_fwd_a_sel = 2'b00;
    o_fwd_b_sel = 2'b00;
    if (w_a_mem)     o_fwd_a_sel = 2'b01;
    else if (w_a_wb) o_fwd_a_sel = 2'b10;
    if (w_b_mem)     o_fwd_b_sel = 2'b01;
    else if (w_b_wb) o_fwd_b_sel = 2'b10;
  end

  assign w_lu = r_ex_valid & r_ex_load & (r_ex_rd != 5'd0) &
                ((i_id_use_rs & (i_id_rs == r_ex_rd)) |
                 (i_id_use_rt & (i_id_rt == r_ex_rd)));

  assign o_md_busy = (r_cnt != '0);
  assign w_mdh     = o_md_busy & (i_id_md_use | i_id_md_start);

  assign w_stall  = (w_lu | w_mdh) & ~i_flush;
  assign w_accept = ~w_stall & ~i_flush;
  assign o_stall  = w_stall;
  assign o_bubble = w_stall | i_flush;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_rd        <= 5'd0;
      r_ex_regwrite  <= 1'b0;
      r_ex_load      <= 1'b0;
      r_ex_rs        <= 5'd0;
      r_ex_rt        <= 5'd0;
      r_ex_use_rs    <= 1'b0;
      r_ex_use_rt    <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= 5'd0;
      r_mem_regwrite <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_regwrite  <= 1'b0;
      r_cnt          <= '0;
    end else begin
      r_wb_valid     <= r_mem_valid;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;
      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;

      if (w_accept) begin
        r_ex_valid    <= 1'b1;
        r_ex_rd       <= i_id_rd;
        r_ex_regwrite <= i_id_regwrite;
        r_ex_load     <= i_id_load;
        r_ex_rs       <= i_id_rs;
        r_ex_rt       <= i_id_rt;
        r_ex_use_rs   <= i_id_use_rs;
        r_ex_use_rt   <= i_id_use_rt;
      end else begin
        r_ex_valid    <= 1'b0;
        r_ex_rd       <= 5'd0;
        r_ex_regwrite <= 1'b0;
        r_ex_load     <= 1'b0;
        r_ex_rs       <= 5'd0;
        r_ex_rt       <= 5'd0;
        r_ex_use_rs   <= 1'b0;
        r_ex_use_rt   <= 1'b0;
      end

      if (w_accept && i_id_md_start) r_cnt <= LP_MD_LOAD;
      else if (r_cnt != '0)          r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Table-driven bench for hazard_fwd_ctrl: one record per cycle holding the ID-stage
// instruction plus the selects/stall/bubble/busy expected while it sits in ID.
module tb_hazard_fwd_ctrl;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       useRs;
    logic       useRt;
    logic       regwrite;
    logic       load;
    logic       mdStart;
    logic       mdUse;
  } instr_t;

  typedef struct {
    string      name;
    instr_t     ins;
    logic       rst;
    logic       flush;
    logic [1:0] expA;
    logic [1:0] expB;
    logic       expStall;
    logic       expBubble;
    logic       expBusy;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [4:0] idRs, idRt, idRd;
  logic       idUseRs, idUseRt, idRegwrite, idLoad, idMdStart, idMdUse, flush;
  logic [1:0] fwdA, fwdB;
  logic       stall, bubble, mdBusy;

  int nVectors;
  int nMiscompares;
  vec_t vecs[$];

  hazard_fwd_ctrl #(.MD_CYCLES(4), .CNT_W(3)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_id_rs       (idRs),
    .i_id_rt       (idRt),
    .i_id_use_rs   (idUseRs),
    .i_id_use_rt   (idUseRt),
    .i_id_rd       (idRd),
    .i_id_regwrite (idRegwrite),
    .i_id_load     (idLoad),
    .i_id_md_start (idMdStart),
    .i_id_md_use   (idMdUse),
    .i_flush       (flush),
    .o_fwd_a_sel   (fwdA),
    .o_fwd_b_sel   (fwdB),
    .o_stall       (stall),
    .o_bubble      (bubble),
    .o_md_busy     (mdBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t mkNop();
    instr_t i;
    i = '{rs: 5'd0, rt: 5'd0, rd: 5'd0, useRs: 1'b0, useRt: 1'b0,
          regwrite: 1'b0, load: 1'b0, mdStart: 1'b0, mdUse: 1'b0};
    return i;
  endfunction

  function automatic instr_t mkAlu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    instr_t i;
    i = mkNop();
    i.rd = rd; i.rs = rs; i.rt = rt;
    i.useRs = 1'b1; i.useRt = 1'b1; i.regwrite = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkImm(input logic [4:0] rd, input logic [4:0] rs);
    instr_t i;
    i = mkNop();
    i.rd = rd; i.rs = rs; i.useRs = 1'b1; i.regwrite = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkLoad(input logic [4:0] rd, input logic [4:0] base);
    instr_t i;
    i = mkImm(rd, base);
    i.load = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkMult(input logic [4:0] rs, input logic [4:0] rt);
    instr_t i;
    i = mkNop();
    i.rs = rs; i.rt = rt; i.useRs = 1'b1; i.useRt = 1'b1; i.mdStart = 1'b1;
    return i;
  endfunction

  function automatic instr_t mkMflo(input logic [4:0] rd);
    instr_t i;
    i = mkNop();
    i.rd = rd; i.regwrite = 1'b1; i.mdUse = 1'b1;
    return i;
  endfunction

  task automatic addVec(input string name, input instr_t ins, input logic r, input logic f,
                        input logic [1:0] a, input logic [1:0] b,
                        input logic st, input logic bu, input logic busy);
    vec_t v;
    v.name = name; v.ins = ins; v.rst = r; v.flush = f;
    v.expA = a; v.expB = b; v.expStall = st; v.expBubble = bu; v.expBusy = busy;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst        = v.rst;
    flush      = v.flush;
    idRs       = v.ins.rs;
    idRt       = v.ins.rt;
    idRd       = v.ins.rd;
    idUseRs    = v.ins.useRs;
    idUseRt    = v.ins.useRt;
    idRegwrite = v.ins.regwrite;
    idLoad     = v.ins.load;
    idMdStart  = v.ins.mdStart;
    idMdUse    = v.ins.mdUse;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    nVectors++;
    if (fwdA !== v.expA) begin
      nMiscompares++;
      $display("[TB] FAIL v%0d %s fwd_a_sel: got %b want %b", idx, v.name, fwdA, v.expA);
    end
    if (fwdB !== v.expB) begin
      nMiscompares++;
      $display("[TB] FAIL v%0d %s fwd_b_sel: got %b want %b", idx, v.name, fwdB, v.expB);
    end
    if (stall !== v.expStall) begin
      nMiscompares++;
      $display("[TB] FAIL v%0d %s stall: got %b want %b", idx, v.name, stall, v.expStall);
    end
    if (bubble !== v.expBubble) begin
      nMiscompares++;
      $display("[TB] FAIL v%0d %s bubble: got %b want %b", idx, v.name, bubble, v.expBubble);
    end
    if (mdBusy !== v.expBusy) begin
      nMiscompares++;
      $display("[TB] FAIL v%0d %s md_busy: got %b want %b", idx, v.name, mdBusy, v.expBusy);
    end
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;

    // name, ID instruction, rst, flush, expA, expB, stall, bubble, md_busy
    addVec("reset_state", mkNop(),              0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("b2b_add",     mkAlu(5'd3, 5'd1, 5'd2), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("b2b_sub_id",  mkAlu(5'd5, 5'd3, 5'd4), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("b2b_sub_ex",  mkNop(),              0, 0, 2'b01, 2'b00, 0, 0, 0);
    addVec("d2_add",      mkAlu(5'd3, 5'd1, 5'd2), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("d2_nop",      mkNop(),              0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("d2_or_id",    mkAlu(5'd6, 5'd7, 5'd3), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("d2_or_ex",    mkNop(),              0, 0, 2'b00, 2'b10, 0, 0, 0);
    addVec("r0_add",      mkAlu(5'd0, 5'd1, 5'd2), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("r0_nop",      mkNop(),              0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("r0_or_id",    mkAlu(5'd6, 5'd7, 5'd0), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("r0_or_ex",    mkNop(),              0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("lu_lw",       mkLoad(5'd8, 5'd1),   0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("lu_stall",    mkImm(5'd9, 5'd8),    0, 0, 2'b00, 2'b00, 1, 1, 0);
    addVec("lu_release",  mkImm(5'd9, 5'd8),    0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("lu_addi_ex",  mkNop(),              0, 0, 2'b10, 2'b00, 0, 0, 0);
    addVec("dw_add1",     mkAlu(5'd2, 5'd1, 5'd1), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("dw_add2",     mkAlu(5'd2, 5'd3, 5'd3), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("dw_xor_id",   mkAlu(5'd1, 5'd2, 5'd2), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("dw_xor_ex",   mkNop(),              0, 0, 2'b01, 2'b01, 0, 0, 0);
    addVec("md_mult",     mkMult(5'd10, 5'd11), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      addVec("md_stall",  mkMflo(5'd12),        0, 0, 2'b00, 2'b00, 1, 1, 1);
    addVec("md_accept",   mkMflo(5'd12),        0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("md_after",    mkNop(),              0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("fl_lw",       mkLoad(5'd8, 5'd1),   0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("fl_lu",       mkImm(5'd9, 5'd8),    0, 1, 2'b00, 2'b00, 0, 1, 0);
    addVec("fl_mult",     mkMult(5'd10, 5'd11), 0, 1, 2'b00, 2'b00, 0, 1, 0);
    addVec("fl_no_busy",  mkNop(),              0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("rs_mult",     mkMult(5'd10, 5'd11), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("rs_stall",    mkMflo(5'd12),        0, 0, 2'b00, 2'b00, 1, 1, 1);
    addVec("rs_assert",   mkMflo(5'd12),        1, 0, 2'b00, 2'b00, 1, 1, 1);
    addVec("rs_cleared",  mkMflo(5'd12),        0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("rs_mflo_ex",  mkNop(),              0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("rs2_add",     mkAlu(5'd5, 5'd1, 5'd2), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("rs2_assert",  mkNop(),              1, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("rs2_use_id",  mkAlu(5'd6, 5'd5, 5'd5), 0, 0, 2'b00, 2'b00, 0, 0, 0);
    addVec("rs2_use_ex",  mkNop(),              0, 0, 2'b00, 2'b00, 0, 0, 0);

    // Initial reset with an idle ID stage; nothing checked until it is released.
    applyStimulus('{name: "init", ins: mkNop(), rst: 1'b1, flush: 1'b0,
                    expA: 2'b00, expB: 2'b00, expStall: 1'b0, expBubble: 1'b0, expBusy: 1'b0});
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(vecs[i], i);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
